// File: rtl/seq_alu.sv
// seq_alu: handshaked sequential ALU with IDLE/BUSY/DONE control and a W-step shift-add multiplier.
// Define SEQ_ALU_MUL_EN to build the multiplier; otherwise opcode 1000 is reported as illegal.
module seq_alu #(
    parameter int W   = 9,
    parameter int SHW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   alu_cmd,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] rslt,
    output logic         flag,
    output logic         zero,
    output logic         err
);
`ifdef SEQ_ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif
    state_t         state_q;
    logic [W-1:0]   rslt_q;
    logic           flag_q, zero_q, err_q;
    logic [W-1:0]   res_d;
    logic           flg_d, err_d;
    logic [SHW-1:0] sh;
    logic [W:0]     add_w, sub_w, lsl_w, lsr_w;

    assign sh    = inB[SHW-1:0];
    assign add_w = {1'b0, inA} + {1'b0, inB};
    assign sub_w = {1'b0, inA} - {1'b0, inB};
    // Guard bits catch the last bit shifted out; over-range shifts fall off to zero.
    assign lsl_w = {1'b0, inA} << sh;
    assign lsr_w = {inA, 1'b0} >> sh;

    always_comb begin
        res_d = '0;
        flg_d = 1'b0;
        err_d = 1'b0;
        case (alu_cmd)
            4'h0:    {flg_d, res_d} = add_w;
            4'h1:    {flg_d, res_d} = lsl_w;
            4'h2:    {res_d, flg_d} = lsr_w;
            4'h3:    res_d = inA ^ inB;
            4'h4:    res_d = inA & inB;
            4'h5:    res_d = inA | inB;
            4'h6:    {flg_d, res_d} = sub_w;
            4'h7:    flg_d = (inA == inB);
            default: err_d = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    logic [W-1:0]   mcand_q;
    logic [2*W-1:0] prod_q, prod_d;
    logic [CW-1:0]  cnt_q;
    logic [W:0]     psum;
    // Multiplier starts in the low half and is consumed one bit per step as the sum shifts in.
    assign psum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_d = {psum, prod_q[W-1:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rslt_q  <= '0;
            flag_q  <= 1'b0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
                    if (alu_cmd == 4'h8) begin
                        state_q <= BUSY;
                        mcand_q <= inA;
                        prod_q  <= {{W{1'b0}}, inB};
                        cnt_q   <= '0;
                    end else
`endif
                    begin
                        state_q <= DONE;
                        rslt_q  <= res_d;
                        flag_q  <= flg_d;
                        zero_q  <= (res_d == '0);
                        err_q   <= err_d;
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                BUSY: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        rslt_q  <= prod_d[W-1:0];
                        flag_q  <= |prod_d[2*W-1:W];
                        zero_q  <= (prod_d[W-1:0] == '0);
                        err_q   <= 1'b0;
                    end
                end
`endif
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign rslt      = rslt_q;
    assign flag      = flag_q;
    assign zero      = zero_q;
    assign err       = err_q;
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter W, default 9, data-path width in bits (W >= 4).
REQ-002 The block SHALL have parameter SHW, default $clog2(W+1), width of the shift-amount field taken from inB[SHW-1:0].
REQ-003 Port clk, input, 1: single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1: operation request.
REQ-006 Port in_ready, output, 1: block can accept a request.
REQ-007 Port alu_cmd, input, 4: opcode.
REQ-008 Port inA and inB, input, W each: operands.
REQ-009 Port out_valid, output, 1: result available.
REQ-010 Port out_ready, input, 1: consumer accepts the result.
REQ-011 Port rslt, output, W: result.
REQ-012 Port flag, output, 1: jump/carry flag.
REQ-013 Port zero, output, 1: result equals zero.
REQ-014 Port err, output, 1: illegal or disabled opcode.

Function
REQ-015 The block SHALL use an FSM with states IDLE, BUSY and DONE.
- in_ready = (state==IDLE).
- out_valid = (state==DONE).
REQ-016 Acceptance SHALL occur on a rising edge with in_valid && in_ready; opcode and operands are registered at that edge.
REQ-017 Single-cycle ops SHALL go IDLE->DONE at the acceptance edge (latency 1: out_valid high after the first edge following acceptance).
REQ-018 MUL SHALL go IDLE->BUSY and iterate one shift-add step per cycle for exactly W cycles, then BUSY->DONE (latency W+1).
REQ-019 In DONE, rslt/flag/zero/err SHALL hold stable until out_valid && out_ready, then go DONE->IDLE; there is no same-cycle bypass (at most one op per 2 cycles).
REQ-020 in_valid SHALL be ignored in BUSY and DONE; out_ready SHALL be ignored outside DONE.
REQ-021 Opcodes and results:
- 0000 ADD: rslt = (inA+inB) mod 2^W; flag = carry out.
- 0001 LSL: shift inA left by s = inB[SHW-1:0]; flag = last bit shifted out (inA[W-s]); s=0 gives rslt=inA, flag=0; s>W gives rslt=0, flag=0.
- 0010 LSR: as LSL, shifting right; flag = inA[s-1].
- 0011 XOR, 0100 AND, 0101 OR: bitwise; flag=0.
- 0110 SUB: rslt = (inA-inB) mod 2^W; flag = borrow (inB > inA, unsigned).
- 0111 CMP: rslt=0; flag = (inA==inB).
- 1000 MUL: rslt = low W bits of the unsigned product; flag = high W bits nonzero.
REQ-022 Opcodes 1001-1111 SHALL produce rslt=0, flag=0, err=1 with latency 1; err SHALL be 0 for every legal op.
REQ-023 zero SHALL equal (rslt==0) for every op, including CMP and illegal opcodes.
REQ-024 Outputs in IDLE and BUSY SHALL hold the last delivered values, or reset values if none has been delivered.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, rslt=0, flag=0, zero=1, err=0 and clear the multiplier accumulator and counter.
REQ-026 Reset in BUSY or DONE SHALL abandon the operation; no result is delivered after reset release.
REQ-027 in_ready SHALL be high from the first edge after rst_n deasserts.

Configuration
REQ-028 Macro SEQ_ALU_MUL_EN SHALL control the multiplier:
- Defined: MUL behaves per REQ-018 and REQ-021.
- Undefined: no multiplier logic and no BUSY state; opcode 1000 is treated as illegal per REQ-022.

Verification (W=9)
REQ-029 ADD inA=9'h1FF, inB=9'h001 -> rslt=0, flag=1, zero=1, out_valid exactly 1 cycle after acceptance.
REQ-030 SUB inA=5, inB=7 -> rslt=9'h1FE, flag=1, zero=0; CMP inA=inB=9'h0AA -> rslt=0, flag=1.
REQ-031 LSL inA=9'h101, s=1 -> rslt=9'h002, flag=1; LSR inA=9'h003, s=10 -> rslt=0, flag=0.
REQ-032 With SEQ_ALU_MUL_EN: MUL 20*30 -> rslt=88, flag=1, out_valid 10 cycles after acceptance, in_ready low throughout. Without the macro -> err=1, rslt=0, latency 1.
REQ-033 Hold out_ready low for 3 cycles in DONE -> outputs stable and in_ready low; a new in_valid is ignored. out_ready high -> IDLE on the next edge.
REQ-034 Assert rst_n low mid-MUL (cycle 4 of BUSY) -> immediate IDLE and reset outputs; no out_valid pulse after release.
